// File: rtl/jpeg_xpose_pkg.sv
// Shared types and constants for the 8x8 ping-pong transpose buffer.
package jpeg_xpose_pkg;

    localparam int unsigned BLK_N  = 8;
    localparam int unsigned DEF_BW = 8;

    typedef logic [2:0]                    row_idx_t;
    typedef logic                          bank_sel_t;
    typedef logic [BLK_N*DEF_BW-1:0]       word_t;

endpackage

// File: rtl/xpose_bank.sv
// One 8-row register bank: row write port, combinational column (or straight row) read mux.
module xpose_bank
    import jpeg_xpose_pkg::*;
#(
    parameter int unsigned BW = DEF_BW
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  row_idx_t              wr_row,
    input  logic [BLK_N*BW-1:0]   wr_data,
    input  row_idx_t              rd_idx,
    input  logic                  rd_rows,
    output logic [BLK_N*BW-1:0]   rd_data
);

    logic [BLK_N*BW-1:0] mem [BLK_N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    // rd_rows selects a straight row read; otherwise gather sample rd_idx of every row.
    always_comb begin
        rd_data = '0;
        if (rd_rows) begin
            rd_data = mem[rd_idx];
        end else begin
            for (int r = 0; r < BLK_N; r++) begin
                rd_data[(BLK_N-r)*BW-1 -: BW] =
                    mem[r][(BLK_N-int'(rd_idx))*BW-1 -: BW];
            end
        end
    end

endmodule

// File: rtl/transpose_col_reader.sv
// Ping-pong 8x8 row-in / column-out transpose buffer.
// Optional TRANSPOSE_BYPASS_EN adds a per-block `bypass` input that emits rows unchanged.
module transpose_col_reader
    import jpeg_xpose_pkg::*;
#(
    parameter int unsigned BW = DEF_BW
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef TRANSPOSE_BYPASS_EN
    input  logic                  bypass,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLK_N*BW-1:0]   in_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLK_N*BW-1:0]   out_col,
    output logic                  out_last
);

    localparam row_idx_t LAST_IDX = row_idx_t'(BLK_N - 1);

    bank_sel_t           wr_bank;
    bank_sel_t           rd_bank;
    row_idx_t            wr_row;
    row_idx_t            rd_col;
    logic [1:0]          full;
    logic [1:0]          rd_rows;
    logic                wr_fire;
    logic                rd_fire;
    logic [BLK_N*BW-1:0] bank_rd [2];

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign out_last  = out_valid && (rd_col == LAST_IDX);
    // Bank contents are not reset, so mask the mux while nothing is valid.
    assign out_col   = out_valid ? bank_rd[rd_bank] : '0;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        xpose_bank #(
            .BW (BW)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_fire && (wr_bank == bank_sel_t'(b))),
            .wr_row  (wr_row),
            .wr_data (in_row),
            .rd_idx  (rd_col),
            .rd_rows (rd_rows[b]),
            .rd_data (bank_rd[b])
        );
    end

    // Writer only touches a non-full bank and reader only a full one, so the two
    // full-flag updates below can never target the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
            full    <= '0;
        end else begin
            if (wr_fire) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == LAST_IDX) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                end
            end
            if (rd_fire) begin
                rd_col <= rd_col + 3'd1;
                if (rd_col == LAST_IDX) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= !rd_bank;
                end
            end
        end
    end

`ifdef TRANSPOSE_BYPASS_EN
    logic [1:0] byp;

    always_ff @(posedge clk) begin
        if (rst) begin
            byp <= '0;
        end else if (wr_fire && (wr_row == '0)) begin
            byp[wr_bank] <= bypass;
        end
    end

    assign rd_rows = byp;
`else
    assign rd_rows = '0;
`endif

endmodule

// File: tb/tb_transpose_col_reader.sv
// Self-checking bench for transpose_col_reader (table vectors + scoreboard queue).
module tb_transpose_col_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_row = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_col;
    logic        out_last;
`ifdef TRANSPOSE_BYPASS_EN
    logic        bypass = 1'b0;
`endif

    always #5 clk = ~clk;

    transpose_col_reader #(
        .BW (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TRANSPOSE_BYPASS_EN
        .bypass    (bypass),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [63:0] col;
        logic        last;
    } exp_t;

    typedef struct {
        logic [63:0] row;
        logic [63:0] col;
        logic        last;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vt[8];
    int          pass_cnt = 0;
    int          total = 0;
    int          in_stalls = 0;
    bit          mon_en = 1'b0;
    bit          model_en = 1'b1;
    logic [63:0] blk_rows[8];
    int          blk_idx = 0;
    logic        blk_byp = 1'b0;
    logic [63:0] r17;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic logic [63:0] table_row(int r);
        logic [63:0] w;
        for (int c = 0; c < 8; c++) w[(8-c)*8-1 -: 8] = 8'(r * 16 + c);
        return w;
    endfunction

    function automatic logic [63:0] model_col(int c);
        logic [63:0] w;
        for (int r = 0; r < 8; r++) w[(8-r)*8-1 -: 8] = blk_rows[r][(8-c)*8-1 -: 8];
        return w;
    endfunction

    task automatic note_accept(input logic [63:0] row, input logic byp);
        exp_t e;
        if (blk_idx == 0) blk_byp = byp;
        blk_rows[blk_idx] = row;
        blk_idx++;
        if (blk_idx == 8) begin
            blk_idx = 0;
            if (model_en) begin
                for (int c = 0; c < 8; c++) begin
                    e.col  = blk_byp ? blk_rows[c] : model_col(c);
                    e.last = (c == 7);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic send_row(input logic [63:0] row, input logic byp);
        int   guard = 0;
        logic ok = 1'b0;
        bit   done = 1'b0;
        in_valid = 1'b1;
        in_row   = row;
`ifdef TRANSPOSE_BYPASS_EN
        bypass   = byp;
`endif
        while (!done) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) in_stalls++;
            @(posedge clk);
            #1;
            guard++;
            if (ok) done = 1'b1;
            else if (guard > 200) begin
                total++;
                $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected 1");
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (ok) note_accept(row, byp);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb.size() != 0 && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("idle_out_valid", 64'(out_valid), 64'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_col: got %h, expected no output", out_col);
            end else begin
                mon_e = sb.pop_front();
                check("out_col", out_col, mon_e.col);
                check("out_last", 64'(out_last), 64'(mon_e.last));
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            vt[i].row  = table_row(i);
            vt[i].col  = 64'h0010203040506070 + 64'(i) * 64'h0101010101010101;
            vt[i].last = (i == 7);
        end

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_col", out_col, 64'd0);

        // Test 1: table-driven single block with latency check
        model_en  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_row(vt[i].row, 1'b0);
            check("t1_latency_valid", 64'(out_valid), 64'(i == 7));
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_col", out_col, vt[i].col);
            check("t1_last", 64'(out_last), 64'(vt[i].last));
            @(posedge clk);
            #1;
        end
        check("t1_done_valid", 64'(out_valid), 64'd0);
        model_en = 1'b1;
        mon_en   = 1'b1;

        // Test 2: three back-to-back blocks
        in_stalls = 0;
        for (int n = 0; n < 24; n++) send_row({$urandom, $urandom}, 1'b0);
        check("t2_no_stall", 64'(in_stalls), 64'd0);
        wait_drain();

        // Test 3: both banks fill, 17th row held until first block drains
        out_ready = 1'b0;
        for (int n = 0; n < 16; n++) send_row({$urandom, $urandom}, 1'b0);
        @(negedge clk);
        check("t3_full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        r17      = {$urandom, $urandom};
        in_valid = 1'b1;
        in_row   = r17;
        repeat (3) @(posedge clk);
        #1;
        check("t3_held_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 8) check("t3_before_col7", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t3_after_col7", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        note_accept(r17, 1'b0);
        for (int n = 0; n < 7; n++) send_row({$urandom, $urandom}, 1'b0);
        wait_drain();

        // Test 4: stall on column 3
        out_ready = 1'b0;
        for (int n = 0; n < 8; n++) send_row({$urandom, $urandom}, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_stall_valid", 64'(out_valid), 64'd1);
            check("t4_stall_col", out_col, sb[0].col);
            check("t4_stall_last", 64'(out_last), 64'd0);
            @(posedge clk);
            #1;
        end
        check("t4_remaining", 64'(sb.size()), 64'd5);
        out_ready = 1'b1;
        wait_drain();

        // Test 5: reset mid-block
        for (int n = 0; n < 5; n++) send_row({$urandom, $urandom}, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        blk_idx = 0;
        sb.delete();
        check("t5_in_ready", 64'(in_ready), 64'd1);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_out_col", out_col, 64'd0);
        check("t5_out_last", 64'(out_last), 64'd0);
        for (int n = 0; n < 8; n++) send_row({$urandom, $urandom}, 1'b0);
        wait_drain();

`ifdef TRANSPOSE_BYPASS_EN
        // Test 6: bypassed block followed by a transposed block
        for (int n = 0; n < 8; n++) send_row({$urandom, $urandom}, n == 0);
        for (int n = 0; n < 8; n++) send_row({$urandom, $urandom}, 1'b0);
        wait_drain();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
